// File: rtl/constraint_sample_driver.sv
// constraint_sample_driver
//   Stimulus stage for a combinational constraint checker. Generates
//   pseudo-random candidate vectors from K = ceil(VEC_W/32) Galois LFSR
//   lanes, samples the checker's satisfied bit in the same cycle, and hands
//   each satisfying vector downstream over valid/ready until HIT_TARGET
//   solutions are accepted or TRIAL_LIMIT candidates have been checked.
//
//   Optional feature macro: FAIL_STREAK_EN (adds max_streak output).
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start, seed   start/restart pulse (IDLE/DONE only), run seed
//   cand_o        registered candidate vector to checker inputs
//   sat_i         checker satisfied bit, combinational from cand_o
//   sol_valid/sol_ready/sol_data   solution handshake and captured vector
//   busy, done, exhausted          run status
//   trial_count, hit_count         per-run counters
//   max_streak    (FAIL_STREAK_EN) longest run of failing trials this run
module constraint_sample_driver #(
    parameter int unsigned VEC_W       = 64,
    parameter int unsigned HIT_TARGET  = 4,
    parameter int unsigned TRIAL_LIMIT = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      seed,
    output logic [VEC_W-1:0] cand_o,
    input  logic             sat_i,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic [VEC_W-1:0] sol_data,
    output logic             busy,
    output logic             done,
    output logic             exhausted,
    output logic [CNT_W-1:0] trial_count,
    output logic [CNT_W-1:0] hit_count
`ifdef FAIL_STREAK_EN
    ,
    output logic [CNT_W-1:0] max_streak
`endif
);

    localparam int unsigned      K         = (VEC_W + 31) / 32;
    localparam logic [31:0]      LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0]      GOLDEN    = 32'h9E37_79B9;
    localparam logic [CNT_W-1:0] TRIAL_MAX = CNT_W'(TRIAL_LIMIT);
    localparam logic [CNT_W-1:0] HIT_MAX   = CNT_W'(HIT_TARGET);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_HOLD,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0]     lane      [K];
    logic [31:0]     lane_seed [K];
    logic [31:0]     lane_step [K];
    logic [K*32-1:0] lane_flat;
    logic [31:0]     mixed;

    logic load, step, capture, inc_trial, inc_hit, set_exh;

    // Per-lane seed mixing and one Galois step; a zero seed would lock the
    // lane at zero, so it is replaced by 1.
    always_comb begin
        mixed     = '0;
        lane_flat = '0;
        for (int unsigned i = 0; i < K; i++) begin
            mixed        = seed ^ (i * GOLDEN);
            lane_seed[i] = (mixed == '0) ? 32'h0000_0001 : mixed;
            lane_step[i] = {1'b0, lane[i][31:1]} ^ (lane[i][0] ? LFSR_MASK : '0);
            lane_flat[i*32 +: 32] = lane[i];
        end
    end

    assign cand_o = lane_flat[VEC_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        inc_trial = 1'b0;
        inc_hit   = 1'b0;
        set_exh   = 1'b0;
        sol_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                busy      = 1'b1;
                inc_trial = 1'b1;
                if (sat_i) begin
                    // Lanes hold so cand_o stays equal to sol_data in HOLD.
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end else if (trial_count + 1'b1 == TRIAL_MAX) begin
                    set_exh   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            S_HOLD: begin
                busy      = 1'b1;
                sol_valid = 1'b1;
                if (sol_ready) begin
                    inc_hit = 1'b1;
                    if (hit_count + 1'b1 == HIT_MAX) begin
                        state_nxt = S_DONE;
                    end else if (trial_count == TRIAL_MAX) begin
                        set_exh   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        step      = 1'b1;
                        state_nxt = S_CHECK;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane        <= '{default: '0};
            sol_data    <= '0;
            trial_count <= '0;
            hit_count   <= '0;
            exhausted   <= 1'b0;
        end else begin
            if (load) begin
                lane        <= lane_seed;
                trial_count <= '0;
                hit_count   <= '0;
                exhausted   <= 1'b0;
            end else if (step) begin
                lane <= lane_step;
            end
            if (inc_trial) trial_count <= trial_count + 1'b1;
            if (inc_hit)   hit_count   <= hit_count + 1'b1;
            if (capture)   sol_data    <= cand_o;
            if (set_exh)   exhausted   <= 1'b1;
        end
    end

`ifdef FAIL_STREAK_EN
    logic [CNT_W-1:0] streak;

    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            streak     <= '0;
            max_streak <= '0;
        end else if (inc_trial) begin
            if (sat_i) begin
                streak <= '0;
            end else begin
                streak <= streak + 1'b1;
                if (streak + 1'b1 > max_streak) max_streak <= streak + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_constraint_sample_driver.sv
// Directed bench for constraint_sample_driver (VEC_W=48 so two LFSR lanes
// are exercised, HIT_TARGET=3, TRIAL_LIMIT=10). Expected candidate values
// are hand-derived from the Galois step s = (s>>1) ^ (s[0] ? 0x80200003 : 0).
module tb_constraint_sample_driver;

    localparam int unsigned VW = 48;
    localparam int unsigned CW = 16;

    // seed = 1: lane0 = 0x00000001, lane1 = 0x9E3779B8 (upper 16 bits used)
    localparam logic [VW-1:0] C0 = 48'h79B8_0000_0001;
    localparam logic [VW-1:0] C1 = 48'hBCDC_8020_0003;
    localparam logic [VW-1:0] C2 = 48'hDE6E_C030_0002;

    logic          clk = 1'b0;
    logic          rst_n, start, sat_i, sol_ready;
    logic [31:0]   seed;
    logic [VW-1:0] cand_o, sol_data;
    logic          sol_valid, busy, done, exhausted;
    logic [CW-1:0] trial_count, hit_count;
`ifdef FAIL_STREAK_EN
    logic [CW-1:0] max_streak;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    constraint_sample_driver #(
        .VEC_W(VW),
        .HIT_TARGET(3),
        .TRIAL_LIMIT(10),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .seed(seed),
        .cand_o(cand_o),
        .sat_i(sat_i),
        .sol_valid(sol_valid),
        .sol_ready(sol_ready),
        .sol_data(sol_data),
        .busy(busy),
        .done(done),
        .exhausted(exhausted),
        .trial_count(trial_count),
        .hit_count(hit_count)
`ifdef FAIL_STREAK_EN
        ,
        .max_streak(max_streak)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; start = 1'b0; sat_i = 1'b0; sol_ready = 1'b0; seed = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Leaves the bench at the first CHECK cycle.
    task automatic pulse_start(input logic [31:0] s);
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; sat_i = 1'b1; sol_ready = 1'b1; seed = 32'hDEAD_BEEF;
        tick();
        tick();
        tests++;
        if ({sol_valid, busy, done, exhausted} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 0000", {sol_valid, busy, done, exhausted});
        end
        tests++;
        if (trial_count !== '0 || hit_count !== '0) begin
            fails++;
            $display("FAIL reset_counts: got trial=%0d hit=%0d expected 0/0", trial_count, hit_count);
        end
        tests++;
        if (cand_o !== '0 || sol_data !== '0) begin
            fails++;
            $display("FAIL reset_data: got cand=%h sol=%h expected 0", cand_o, sol_data);
        end
        rst_n = 1'b1; start = 1'b0; sat_i = 1'b0; sol_ready = 1'b0;
    endtask

    task automatic test_hits();
        logic exp_sv [7];
        logic exp_dn [7];
        exp_sv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        sat_i = 1'b1; sol_ready = 1'b1;
        pulse_start(32'h1);
        for (int c = 1; c <= 7; c++) begin
            tests++;
            if (sol_valid !== exp_sv[c-1] || done !== exp_dn[c-1]) begin
                fails++;
                $display("FAIL hits_cycle%0d: got valid=%b done=%b expected valid=%b done=%b",
                         c, sol_valid, done, exp_sv[c-1], exp_dn[c-1]);
            end
            if (c == 2 || c == 4 || c == 6) begin
                tests++;
                if (sol_data !== (c == 2 ? C0 : (c == 4 ? C1 : C2))) begin
                    fails++;
                    $display("FAIL hits_data%0d: got %h expected %h", c, sol_data,
                             (c == 2 ? C0 : (c == 4 ? C1 : C2)));
                end
            end
            if (c < 7) tick();
        end
        tests++;
        if (hit_count !== 16'd3 || trial_count !== 16'd3 || exhausted !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hits_final: got hit=%0d trial=%0d exh=%b busy=%b expected 3/3/0/0",
                     hit_count, trial_count, exhausted, busy);
        end
    endtask

    task automatic test_exhaust();
        apply_reset();
        sat_i = 1'b0; sol_ready = 1'b1;
        pulse_start(32'h1234);
        for (int k = 1; k <= 10; k++) begin
            tests++;
            if (sol_valid !== 1'b0 || busy !== 1'b1 || trial_count !== CW'(k - 1)) begin
                fails++;
                $display("FAIL exhaust_cycle%0d: got valid=%b busy=%b trial=%0d expected 0/1/%0d",
                         k, sol_valid, busy, trial_count, k - 1);
            end
            tick();
        end
        tests++;
        if (done !== 1'b1 || exhausted !== 1'b1 || trial_count !== 16'd10 || hit_count !== 16'd0) begin
            fails++;
            $display("FAIL exhaust_done: got done=%b exh=%b trial=%0d hit=%0d expected 1/1/10/0",
                     done, exhausted, trial_count, hit_count);
        end
        tick(); tick(); tick();
        tests++;
        if (done !== 1'b1 || trial_count !== 16'd10) begin
            fails++;
            $display("FAIL exhaust_hold: got done=%b trial=%0d expected 1/10", done, trial_count);
        end
        pulse_start(32'h5);
        tests++;
        if (done !== 1'b0 || exhausted !== 1'b0 || trial_count !== 16'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL exhaust_restart: got done=%b exh=%b trial=%0d busy=%b expected 0/0/0/1",
                     done, exhausted, trial_count, busy);
        end
    endtask

    task automatic test_sequence();
        int n;
        apply_reset();
        sat_i = 1'b0; sol_ready = 1'b0;
        pulse_start(32'h1);
        tests++;
        if (cand_o !== C0) begin
            fails++;
            $display("FAIL seq_c0: got %h expected %h", cand_o, C0);
        end
        // start while in CHECK must be ignored
        seed = 32'h0; start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (cand_o !== C1) begin
            fails++;
            $display("FAIL seq_c1: got %h expected %h", cand_o, C1);
        end
        tick();
        tests++;
        if (cand_o !== C2) begin
            fails++;
            $display("FAIL seq_c2: got %h expected %h", cand_o, C2);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL seq_timeout: got done=%b expected 1", done);
        end
        pulse_start(32'h0);
        tests++;
        if (cand_o[31:0] !== 32'h0000_0001 || cand_o[47:32] !== 16'h79B9) begin
            fails++;
            $display("FAIL seq_seed0: got %h expected 79b900000001", cand_o);
        end
        tick();
        tests++;
        if (cand_o[31:0] !== 32'h8020_0003) begin
            fails++;
            $display("FAIL seq_seed0_s1: got %h expected 80200003", cand_o[31:0]);
        end
        tick();
        tests++;
        if (cand_o[31:0] !== 32'hC030_0002) begin
            fails++;
            $display("FAIL seq_seed0_s2: got %h expected c0300002", cand_o[31:0]);
        end
    endtask

    task automatic test_back_to_back_stall();
        apply_reset();
        sat_i = 1'b1; sol_ready = 1'b0;
        pulse_start(32'h1);
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (sol_valid !== 1'b1 || sol_data !== C0 || cand_o !== C0 ||
                trial_count !== 16'd1 || hit_count !== 16'd0) begin
                fails++;
                $display("FAIL stall_%0d: got valid=%b data=%h cand=%h trial=%0d hit=%0d expected 1/%h/%h/1/0",
                         i, sol_valid, sol_data, cand_o, trial_count, hit_count, C0, C0);
            end
            tick();
        end
        sol_ready = 1'b1; sat_i = 1'b0;
        tick();
        tests++;
        if (sol_valid !== 1'b0 || hit_count !== 16'd1 || cand_o !== C1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL stall_release: got valid=%b hit=%0d cand=%h busy=%b expected 0/1/%h/1",
                     sol_valid, hit_count, cand_o, busy, C1);
        end
    endtask

    task automatic test_reset_in_hold();
        apply_reset();
        sat_i = 1'b1; sol_ready = 1'b0;
        pulse_start(32'h1);
        tick();
        tests++;
        if (sol_valid !== 1'b1) begin
            fails++;
            $display("FAIL rsthold_pre: got valid=%b expected 1", sol_valid);
        end
        rst_n = 1'b0;
        tick();
        tests++;
        if (sol_valid !== 1'b0 || busy !== 1'b0 || trial_count !== '0 || hit_count !== '0 || sol_data !== '0) begin
            fails++;
            $display("FAIL rsthold_post: got valid=%b busy=%b trial=%0d hit=%0d data=%h expected all 0",
                     sol_valid, busy, trial_count, hit_count, sol_data);
        end
        rst_n = 1'b1; sol_ready = 1'b1;
        pulse_start(32'h1);
        tick();
        tests++;
        if (sol_valid !== 1'b1 || sol_data !== C0) begin
            fails++;
            $display("FAIL rsthold_rerun: got valid=%b data=%h expected 1/%h", sol_valid, sol_data, C0);
        end
        tick();
        tests++;
        if (hit_count !== 16'd1 || sol_valid !== 1'b0) begin
            fails++;
            $display("FAIL rsthold_hit: got hit=%0d valid=%b expected 1/0", hit_count, sol_valid);
        end
    endtask

    task automatic test_final_trial_hit();
        apply_reset();
        sat_i = 1'b0; sol_ready = 1'b1;
        pulse_start(32'h77);
        for (int i = 0; i < 9; i++) tick();
        tests++;
        if (busy !== 1'b1 || trial_count !== 16'd9) begin
            fails++;
            $display("FAIL final_pre: got busy=%b trial=%0d expected 1/9", busy, trial_count);
        end
        sat_i = 1'b1;
        tick();
        tests++;
        if (sol_valid !== 1'b1 || trial_count !== 16'd10) begin
            fails++;
            $display("FAIL final_hold: got valid=%b trial=%0d expected 1/10", sol_valid, trial_count);
        end
        tick();
        tests++;
        if (done !== 1'b1 || exhausted !== 1'b1 || hit_count !== 16'd1) begin
            fails++;
            $display("FAIL final_done: got done=%b exh=%b hit=%0d expected 1/1/1", done, exhausted, hit_count);
        end
    endtask

`ifdef FAIL_STREAK_EN
    task automatic test_streak();
        logic pat [6];
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        sol_ready = 1'b1;
        pulse_start(32'h9);
        for (int i = 0; i < 6; i++) begin
            sat_i = pat[i];
            tick();
            // after a hit, spend the HOLD cycle handing the solution off
            if (pat[i] && i < 5) tick();
        end
        tests++;
        if (max_streak !== 16'd3 || hit_count !== 16'd1 || sol_valid !== 1'b1) begin
            fails++;
            $display("FAIL streak: got max=%0d hit=%0d valid=%b expected 3/1/1",
                     max_streak, hit_count, sol_valid);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_hits();
        test_exhaust();
        test_sequence();
        test_back_to_back_stall();
        test_reset_in_hold();
        test_final_trial_hit();
`ifdef FAIL_STREAK_EN
        test_streak();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
